// File: rtl/otp_stream_cipher.sv
// One-time-pad encrypt/decrypt engine: LFSR pad generator, DEPTH-slot pad store, one output register.
// Define OTP_BURN_EN to clear and zero a slot after its first successful decrypt.
module otp_stream_cipher #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'h0001,
    localparam int unsigned      IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_err,
    output logic              pad_full
);

    localparam logic [LFSR_W-1:0] SeedEff = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              pad_full_q, pad_full_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_err_q, out_err_d;

    logic [DATA_W-1:0] pad_mem_q [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              accept;
    logic [DATA_W-1:0] pad;

    assign in_ready = !clr && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pad      = lfsr_q[DATA_W-1:0];

    always_comb begin
        lfsr_adv = lfsr_q;
        for (int i = 0; i < DATA_W; i++) begin
            lfsr_adv = lfsr_step(lfsr_adv);
        end
    end

    always_comb begin
        lfsr_d      = lfsr_q;
        wr_ptr_d    = wr_ptr_q;
        valid_d     = valid_q;
        pad_full_d  = pad_full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_err_d   = out_err_q;
        mem_we      = 1'b0;
        mem_addr    = wr_ptr_q;
        mem_wdata   = pad;

        if (accept) begin
            // Rejections default to err with zeroed payload; success paths override.
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_data_d  = '0;
            out_idx_d   = '0;
            if (!in_mode) begin
                if (!pad_full_q) begin
                    out_data_d        = in_data ^ pad;
                    out_idx_d         = wr_ptr_q;
                    out_err_d         = 1'b0;
                    mem_we            = 1'b1;
                    valid_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d          = wr_ptr_q + IDX_W'(1);
                    lfsr_d            = lfsr_adv;
                    if (wr_ptr_q == IDX_W'(DEPTH - 1)) begin
                        pad_full_d = 1'b1;
                    end
                end
            end else begin
                out_idx_d = in_idx;
                if (valid_q[in_idx]) begin
                    out_data_d = in_data ^ pad_mem_q[in_idx];
                    out_err_d  = 1'b0;
`ifdef OTP_BURN_EN
                    valid_d[in_idx] = 1'b0;
                    mem_we          = 1'b1;
                    mem_addr        = in_idx;
                    mem_wdata       = '0;
`endif
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // clr never coincides with an accept, so it only touches store bookkeeping.
        if (clr) begin
            wr_ptr_d   = '0;
            valid_d    = '0;
            pad_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q      <= SeedEff;
            wr_ptr_q    <= '0;
            valid_q     <= '0;
            pad_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            wr_ptr_q    <= wr_ptr_d;
            valid_q     <= valid_d;
            pad_full_q  <= pad_full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_err_q   <= out_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            pad_mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_err   = out_err_q;
    assign pad_full  = pad_full_q;

endmodule

// File: doc/otp_stream_cipher.md
Name: otp_stream_cipher

Overview:
Parametrised one-time-pad encrypt/decrypt engine. It generates pads from an internal Fibonacci LFSR and keeps each pad in a DEPTH-entry pad store indexed by slot. Encrypt consumes a fresh pad and returns ciphertext plus the slot index. Decrypt reads the pad back by index. Sits between the tile I/O adapter and the host. Uses valid/ready on both sides, with a single registered output stage.

Parameters:
DATA_W, 8, data and pad width in bits
DEPTH, 16, pad store entries; power of two, >= 2
IDX_W, $clog2(DEPTH), slot index width (derived, not overridden)
LFSR_W, 16, LFSR state width; must be >= DATA_W
LFSR_TAPS, 16'hB400, feedback tap mask (bit i set = state bit i taps)
LFSR_SEED, 16'h0001, reset state; a zero seed is replaced by 1

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
clr  in  1  pulse: empty the pad store and reset the write pointer; LFSR is not reseeded
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_mode  in  1  0 = encrypt, 1 = decrypt
in_data  in  DATA_W  plaintext (encrypt) or ciphertext (decrypt)
in_idx  in  IDX_W  slot to decrypt with; ignored on encrypt
out_valid  out  1  result valid
out_ready  in  1  consumer accepts when out_valid & out_ready
out_data  out  DATA_W  result; 0 when out_err = 1
out_idx  out  IDX_W  encrypt: slot written; decrypt: echo of in_idx
out_err  out  1  request rejected (see Behaviour)
pad_full  out  1  all DEPTH slots written since the last reset or clr

Behaviour:
- Reset state: out_valid = 0, out_data = 0, out_idx = 0, out_err = 0, pad_full = 0, wr_ptr = 0, all slot-valid bits = 0, lfsr = LFSR_SEED (or 1 if the seed is 0). Pad RAM contents need no reset.
- in_ready = !clr && (!out_valid || out_ready). This is a single output register, so throughput is 1 per cycle.
- Latency: a request accepted at edge N appears on the out_* ports after edge N, i.e. 1 cycle.
- out_* hold stable while out_valid && !out_ready.
- LFSR single step: fb = ^(lfsr & LFSR_TAPS); lfsr <= {lfsr[LFSR_W-2:0], fb}.
- Current pad = lfsr[DATA_W-1:0].
- Accepted encrypt with !pad_full:
  - out_data = in_data ^ pad; out_idx = wr_ptr; out_err = 0.
  - pad[wr_ptr] <= pad; valid[wr_ptr] <= 1; wr_ptr++.
  - LFSR advances DATA_W steps in one cycle (unrolled).
  - pad_full sets when wr_ptr wraps from DEPTH-1 to 0.
- Accepted encrypt with pad_full: out_err = 1, out_data = 0, out_idx = 0. No store write, no LFSR advance.
- Accepted decrypt:
  - Slot valid: out_data = in_data ^ pad[in_idx], out_err = 0.
  - Slot not valid: out_err = 1, out_data = 0.
  - Decrypt never advances the LFSR or wr_ptr. It is allowed while pad_full = 1.
- clr = 1: wr_ptr <= 0, valid <= 0, pad_full <= 0. No request is accepted that cycle. A pending output is not cancelled.
- Decrypt of the slot being written in the same cycle cannot occur, because there is only one request per cycle.
- rst_n low mid-transfer: the pending output is dropped and the block returns to the reset state.

Optional Feature:
OTP_BURN_EN.
- Defined: strict one-time use. A successful decrypt clears valid[in_idx] and overwrites pad[in_idx] with 0. A second decrypt of the same slot returns out_err = 1.
- Not defined: pads persist until clr or reset, and repeated decrypts of a slot return identical results.

Test Plan:
1. Reset with defaults, encrypt 0xA5 -> out_data 0xA4, out_idx 0, out_err 0. Then encrypt 0x3C -> out_data 0x3C (pad 0x00, lfsr 0x0100), out_idx 1.
2. Decrypt idx 0 with 0xA4 -> out_data 0xA5, out_err 0. Decrypt idx 5 (never written) -> out_err 1, out_data 0x00.
3. Issue 16 encrypts -> pad_full = 1 after the 16th. 17th encrypt -> out_err 1 and LFSR unchanged (the next encrypt after clr uses the same pad the rejected one would have). Decrypt idx 15 still succeeds.
4. Backpressure: hold out_ready = 0 for 3 cycles with in_valid high -> in_ready = 0 after the first accept, out_* stable, no request lost or duplicated when out_ready returns to 1.
5. clr asserted together with in_valid -> request not accepted (in_ready 0); next encrypt gets out_idx 0 and pad_full = 0.
6. With OTP_BURN_EN: encrypt, decrypt idx 0 twice -> first out_err 0, second out_err 1. Without the macro: both decrypts return identical data with out_err 0.
